// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM-to-WB pipeline register of the RISC-V core.
// Registers the MEM-stage result, extracts and sign/zero-extends load data,
// selects the writeback source and gates the register-file write enable for
// bubbles, x0 destinations and faulting loads.
// Optional feature macro: MEM_WB_INSTRET_EN adds a retired-instruction
// counter on `instret`; when undefined the port is tied to zero.
module mem_wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      pc_plus4,
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  input  logic [1:0]       wb_sel,
  input  logic [4:0]       rd_in,
  input  logic             reg_wen_in,
  output logic [31:0]      wb,
  output logic [4:0]       rd,
  output logic             RegWen,
  output logic             wb_valid,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_ZERO = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic        load_fault;
  logic        load_error;
  logic [31:0] wb_next;
  logic        reg_wen_next;
  logic        advance;

  // Pick the addressed byte and halfword out of the aligned memory word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    byte_lane = mem_rdata[7:0];
    case (addr_lo)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Extend the selected lane per funct3 and flag misaligned or unknown widths.
  always_comb begin
    load_data  = 32'd0;
    load_fault = 1'b0;
    case (funct3)
      F3_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU: load_data = {24'd0, byte_lane};
      F3_LH: begin
        load_data  = {{16{half_lane[15]}}, half_lane};
        load_fault = addr_lo[0];
      end
      F3_LHU: begin
        load_data  = {16'd0, half_lane};
        load_fault = addr_lo[0];
      end
      F3_LW: begin
        load_data  = mem_rdata;
        load_fault = (addr_lo != 2'b00);
      end
      default: load_fault = 1'b1;
    endcase
  end

  // A fault only matters when the load path is the writeback source.
  assign load_error = (wb_sel_e'(wb_sel) == SEL_LOAD) && load_fault;

  // Writeback source mux; a faulting load writes back zero.
  always_comb begin
    wb_next = 32'd0;
    case (wb_sel_e'(wb_sel))
      SEL_ALU:  wb_next = alu_result;
      SEL_LOAD: wb_next = load_error ? 32'd0 : load_data;
      SEL_PC4:  wb_next = pc_plus4;
      default:  wb_next = 32'd0;
    endcase
  end

  // x0 is hard-wired zero, so its write enable is suppressed while the data still flows.
  assign reg_wen_next = in_valid && reg_wen_in && (rd_in != 5'd0) && !load_error;

  // An instruction retires into WB on a normal (unstalled, unflushed) edge.
  assign advance = !stall && !flush;

  // Pipeline register: flush kills, stall holds (error pulse still clears), else capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
      wb       <= 32'd0;
      rd       <= 5'd0;
      RegWen   <= 1'b0;
      wb_valid <= 1'b0;
      load_err <= 1'b0;
    end else if (flush) begin
      RegWen   <= 1'b0;
      wb_valid <= 1'b0;
      load_err <= 1'b0;
    end else if (stall) begin
      load_err <= 1'b0;
    end else begin
      wb       <= wb_next;
      rd       <= rd_in;
      RegWen   <= reg_wen_next;
      wb_valid <= in_valid;
      load_err <= in_valid && load_error;
    end
  end

`ifdef MEM_WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Count every valid instruction entering WB, including x0 writes and faulting loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (advance && in_valid) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign instret = instret_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign instret        = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed, table-driven bench for mem_wb_stage.
// The DUT counter is built 4 bits wide so wrap-around is reachable quickly;
// expected instret follows MEM_WB_INSTRET_EN the same way the design does.
module tb_mem_wb_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, stall, flush;
  logic [31:0]   alu_result, mem_rdata, pc_plus4;
  logic [1:0]    addr_lo, wb_sel;
  logic [2:0]    funct3;
  logic [4:0]    rd_in;
  logic          reg_wen_in;
  logic [31:0]   wb;
  logic [4:0]    rd;
  logic          RegWen, wb_valid, load_err;
  logic [CW-1:0] instret;

  int n_total = 0;
  int n_pass  = 0;
  int model_cnt = 0;

  mem_wb_stage #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .alu_result (alu_result),
    .mem_rdata  (mem_rdata),
    .pc_plus4   (pc_plus4),
    .addr_lo    (addr_lo),
    .funct3     (funct3),
    .wb_sel     (wb_sel),
    .rd_in      (rd_in),
    .reg_wen_in (reg_wen_in),
    .wb         (wb),
    .rd         (rd),
    .RegWen     (RegWen),
    .wb_valid   (wb_valid),
    .load_err   (load_err),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [4:0]  rdi;
    logic        wen;
    logic [31:0] e_wb;
    logic        e_wen;
    logic        e_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef MEM_WB_INSTRET_EN
    return 32'(model_cnt % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [1:0] off, input logic [2:0] f3, input logic [1:0] sel,
                       input logic [4:0] rdi, input logic wen);
    in_valid   = v;
    alu_result = alu;
    pc_plus4   = pc4;
    addr_lo    = off;
    funct3     = f3;
    wb_sel     = sel;
    rd_in      = rdi;
    reg_wen_in = wen;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wb"}, wb, 32'd0);
    check({tag, " rd"}, {27'd0, rd}, 32'd0);
    check({tag, " RegWen"}, {31'd0, RegWen}, 32'd0);
    check({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check({tag, " load_err"}, {31'd0, load_err}, 32'd0);
    check({tag, " instret"}, {28'd0, instret}, 32'd0);
  endtask

  logic [31:0] hold_wb;
  logic [4:0]  hold_rd;
  logic [31:0] hold_cnt;

  initial begin
    //          name        v  alu          pc4       off   f3      sel    rd  wen  e_wb          e_wen e_err
    vecs[0]  = '{"add",     1, 32'h1234,    32'h0,    2'd0, 3'b000, 2'b00, 5,  1,   32'h0000_1234, 1, 0};
    vecs[1]  = '{"lb3",     1, 32'h3,       32'h0,    2'd3, 3'b000, 2'b01, 6,  1,   32'hFFFF_FF80, 1, 0};
    vecs[2]  = '{"lbu1",    1, 32'h1,       32'h0,    2'd1, 3'b100, 2'b01, 6,  1,   32'h0000_007F, 1, 0};
    vecs[3]  = '{"lh2",     1, 32'h2,       32'h0,    2'd2, 3'b001, 2'b01, 6,  1,   32'hFFFF_80FF, 1, 0};
    vecs[4]  = '{"lhu0",    1, 32'h0,       32'h0,    2'd0, 3'b101, 2'b01, 6,  1,   32'h0000_7F01, 1, 0};
    vecs[5]  = '{"lw0",     1, 32'h0,       32'h0,    2'd0, 3'b010, 2'b01, 6,  1,   32'h80FF_7F01, 1, 0};
    vecs[6]  = '{"lw2_err", 1, 32'h2,       32'h0,    2'd2, 3'b010, 2'b01, 7,  1,   32'h0,         0, 1};
    vecs[7]  = '{"lh1_err", 1, 32'h1,       32'h0,    2'd1, 3'b001, 2'b01, 7,  1,   32'h0,         0, 1};
    vecs[8]  = '{"f110err", 1, 32'h0,       32'h0,    2'd0, 3'b110, 2'b01, 7,  1,   32'h0,         0, 1};
    vecs[9]  = '{"x0",      1, 32'h55,      32'h0,    2'd1, 3'b000, 2'b00, 0,  1,   32'h0000_0055, 0, 0};
    vecs[10] = '{"jal",     1, 32'h999,     32'h104,  2'd0, 3'b000, 2'b10, 1,  1,   32'h0000_0104, 1, 0};
    vecs[11] = '{"sel11",   1, 32'hDEAD,    32'h44,   2'd0, 3'b000, 2'b11, 3,  1,   32'h0,         1, 0};
    vecs[12] = '{"bubble",  0, 32'h77,      32'h0,    2'd0, 3'b000, 2'b00, 4,  1,   32'h0000_0077, 0, 0};
    vecs[13] = '{"nowen",   1, 32'h9,       32'h0,    2'd0, 3'b000, 2'b00, 10, 0,   32'h0000_0009, 0, 0};
    vecs[14] = '{"lb0",     1, 32'h0,       32'h0,    2'd0, 3'b000, 2'b01, 11, 1,   32'h0000_0001, 1, 0};
    vecs[15] = '{"lhu2",    1, 32'h2,       32'h0,    2'd2, 3'b101, 2'b01, 12, 1,   32'h0000_80FF, 1, 0};

    // Reset is asserted between edges; outputs must be zero with no clock edge.
    rst = 1'b0; stall = 1'b0; flush = 1'b0; mem_rdata = 32'h80FF_7F01;
    drive(0, 32'h0, 32'h0, 2'd0, 3'b000, 2'b00, 5'd0, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Table: one instruction per cycle, one-cycle latency.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].alu, vecs[i].pc4, vecs[i].off, vecs[i].f3,
            vecs[i].sel, vecs[i].rdi, vecs[i].wen);
      tick();
      if (vecs[i].v) model_cnt++;
      check({vecs[i].name, " wb"}, wb, vecs[i].e_wb);
      check({vecs[i].name, " rd"}, {27'd0, rd}, {27'd0, vecs[i].rdi});
      check({vecs[i].name, " RegWen"}, {31'd0, RegWen}, {31'd0, vecs[i].e_wen});
      check({vecs[i].name, " wb_valid"}, {31'd0, wb_valid}, {31'd0, vecs[i].v});
      check({vecs[i].name, " load_err"}, {31'd0, load_err}, {31'd0, vecs[i].e_err});
      check({vecs[i].name, " instret"}, {28'd0, instret}, exp_instret());
    end

    // Stall three cycles with different inputs present: WB holds, counter +1 total.
    drive(1, 32'hABC, 32'h0, 2'd0, 3'b000, 2'b00, 5'd12, 1'b1);
    tick();
    model_cnt++;
    hold_cnt = exp_instret();
    stall = 1'b1;
    drive(1, 32'h5555, 32'h0, 2'd0, 3'b000, 2'b00, 5'd13, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall wb", wb, 32'h0000_0ABC);
      check("stall rd", {27'd0, rd}, 32'd12);
      check("stall RegWen", {31'd0, RegWen}, 32'd1);
      check("stall wb_valid", {31'd0, wb_valid}, 32'd1);
      check("stall instret", {28'd0, instret}, hold_cnt);
    end
    stall = 1'b0;

    // Faulting load followed by a stall: the error pulse lasts exactly one cycle.
    drive(1, 32'h2, 32'h0, 2'd2, 3'b010, 2'b01, 5'd7, 1'b1);
    tick();
    model_cnt++;
    check("fault err", {31'd0, load_err}, 32'd1);
    check("fault wb", wb, 32'd0);
    stall = 1'b1;
    tick();
    check("fault+stall err", {31'd0, load_err}, 32'd0);
    check("fault+stall RegWen", {31'd0, RegWen}, 32'd0);
    check("fault+stall instret", {28'd0, instret}, exp_instret());
    stall = 1'b0;

    // Flush and stall together on a valid instruction: kill it, keep wb/rd.
    drive(1, 32'h321, 32'h0, 2'd0, 3'b000, 2'b00, 5'd9, 1'b1);
    tick();
    model_cnt++;
    hold_wb = wb; hold_rd = rd;
    check("pre-flush wb", wb, 32'h0000_0321);
    flush = 1'b1; stall = 1'b1;
    drive(1, 32'h777, 32'h0, 2'd0, 3'b000, 2'b00, 5'd15, 1'b1);
    tick();
    check("flush RegWen", {31'd0, RegWen}, 32'd0);
    check("flush wb_valid", {31'd0, wb_valid}, 32'd0);
    check("flush wb hold", wb, 32'h0000_0321);
    check("flush rd hold", {27'd0, rd}, 32'd9);
    check("flush instret", {28'd0, instret}, exp_instret());
    flush = 1'b0; stall = 1'b0;

    // Mid-run reset wins immediately, then first post-reset capture.
    stall = 1'b1; flush = 1'b1;
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    model_cnt = 0;
    @(negedge clk); rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1, 32'h0000_1234, 32'h0, 2'd0, 3'b000, 2'b00, 5'd5, 1'b1);
    tick();
    model_cnt++;
    check("post-reset wb", wb, 32'h0000_1234);
    check("post-reset rd", {27'd0, rd}, 32'd5);
    check("post-reset RegWen", {31'd0, RegWen}, 32'd1);

    // 16 more valid instructions: 17 since reset wraps a 4-bit counter to 1.
    for (int k = 0; k < 16; k++) begin
      drive(1, 32'(k), 32'h0, 2'd0, 3'b000, 2'b00, 5'd2, 1'b1);
      tick();
      model_cnt++;
    end
`ifdef MEM_WB_INSTRET_EN
    check("wrap instret", {28'd0, instret}, 32'd1);
`else
    check("wrap instret", {28'd0, instret}, 32'd0);
`endif
    check("wrap wb", wb, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
